// File: rtl/cbus_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// cbus_mem_responder_pkg
// Shared cbus types for the memory-side responder:
//   msize_t           - access size (byte, half-word, word)
//   mlen_t            - burst length encoded as beats-1 (MLEN1=0 .. MLEN16=15)
//   cbus_req_t        - initiator request (valid, is_write, size, addr, strobe, data, len)
//   cbus_resp_t       - responder reply (ready, last, data)
//   cbus_resp_state_t - responder FSM states
//   strobe_merge()    - byte-lane merge helper used by the word array
// ---------------------------------------------------------------------------
package cbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef logic [3:0] mlen_t;

    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        CR_IDLE  = 2'd0,
        CR_WAIT  = 2'd1,
        CR_BURST = 2'd2
    } cbus_resp_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strobe_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strobe
    );
        logic [31:0] merged;
        merged = old_word;
        for (int lane = 0; lane < 4; lane++) begin
            if (strobe[lane]) begin
                merged[lane*8 +: 8] = new_word[lane*8 +: 8];
            end else begin
                merged[lane*8 +: 8] = old_word[lane*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/cbus_mem_array.sv
// ---------------------------------------------------------------------------
// cbus_mem_array
// Byte-strobed 32-bit word array: one combinational read port and one
// synchronous write port. Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable for this clock edge
//   widx   in   write word index
//   wstrb  in   write byte strobes (lane-aligned)
//   wdata  in   write data
//   ridx   in   read word index
//   rdata  out  mem[ridx], combinational
// ---------------------------------------------------------------------------
module cbus_mem_array
    import cbus_mem_responder_pkg::*;
#(
    parameter  int WORDS = 4096,
    localparam int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [WORDS];

    // Byte-strobed write; a zero strobe leaves the word untouched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx] <= strobe_merge(mem_r[widx], wdata, wstrb);
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/cbus_mem_responder.sv
// ---------------------------------------------------------------------------
// cbus_mem_responder
// Slave end of cbus: serves burst reads/writes (cache line fill, dirty-line
// flush, uncached single beats) from an internal word array.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   creq   in   request from initiator (cbus_req_t)
//   cresp  out  response: ready, last, data (cbus_resp_t)
//   busy   out  high whenever the FSM is not idle
// Optional build macro: CBUS_RESP_RANDOM_STALL_EN inserts LFSR-driven
// ready stalls during bursts.
// ---------------------------------------------------------------------------
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter int          LATENCY    = 2,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy
);

    localparam int IW  = $clog2(MEM_WORDS);
    localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = (LATENCY > 0) ? WCW'(LATENCY - 1) : '0;

    cbus_resp_state_t state_r, state_s;
    logic [3:0]       beat_r, beat_s;
    logic [WCW-1:0]   wait_r, wait_s;
    logic [IW-1:0]    base_r, base_s;
    logic             is_write_r, is_write_s;
    mlen_t            len_r, len_s;

    logic             stall_s;
    logic             beat_go_s;
    logic [IW-1:0]    idx_s;
    logic [31:0]      rdata_s;
    logic             unused_bits_s;

`ifdef CBUS_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_r;

    // Galois LFSR (taps 0xB400), free-running from reset; bit 0 requests a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= STALL_SEED;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign stall_s       = lfsr_r[0];
    assign unused_bits_s = ^{creq.size, creq.addr[1:0], creq.addr[31:IW+2]};
`else
    assign stall_s       = 1'b0;
    assign unused_bits_s = ^{creq.size, creq.addr[1:0], creq.addr[31:IW+2], STALL_SEED};
`endif

    // A beat completes only in BURST while the initiator still holds valid.
    assign beat_go_s = (state_r == CR_BURST) && creq.valid && !stall_s;

    // Word index wraps inside the array, so upper address bits alias.
    assign idx_s = base_r + IW'(beat_r);

    // FSM and burst-context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= CR_IDLE;
            beat_r     <= 4'd0;
            wait_r     <= '0;
            base_r     <= '0;
            is_write_r <= 1'b0;
            len_r      <= 4'd0;
        end else begin
            state_r    <= state_s;
            beat_r     <= beat_s;
            wait_r     <= wait_s;
            base_r     <= base_s;
            is_write_r <= is_write_s;
            len_r      <= len_s;
        end
    end

    // Next-state logic: accept, wait out the latency, then stream beats.
    always_comb begin
        state_s    = state_r;
        beat_s     = beat_r;
        wait_s     = wait_r;
        base_s     = base_r;
        is_write_s = is_write_r;
        len_s      = len_r;
        case (state_r)
            CR_IDLE: begin
                if (creq.valid) begin
                    base_s     = creq.addr[IW+1:2];
                    is_write_s = creq.is_write;
                    len_s      = creq.len;
                    beat_s     = 4'd0;
                    if (LATENCY > 0) begin
                        state_s = CR_WAIT;
                        wait_s  = WAIT_LOAD;
                    end else begin
                        state_s = CR_BURST;
                    end
                end else begin
                    state_s = CR_IDLE;
                end
            end
            CR_WAIT: begin
                if (!creq.valid) begin
                    state_s = CR_IDLE;
                end else if (wait_r == '0) begin
                    state_s = CR_BURST;
                end else begin
                    wait_s = wait_r - WCW'(1);
                end
            end
            CR_BURST: begin
                if (!creq.valid) begin
                    state_s = CR_IDLE;
                    beat_s  = 4'd0;
                end else if (stall_s) begin
                    beat_s = beat_r;
                end else if (beat_r == len_r) begin
                    state_s = CR_IDLE;
                    beat_s  = 4'd0;
                end else begin
                    beat_s = beat_r + 4'd1;
                end
            end
            default: begin
                state_s = CR_IDLE;
                beat_s  = 4'd0;
            end
        endcase
    end

    cbus_mem_array #(
        .WORDS (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (beat_go_s && is_write_r),
        .widx  (idx_s),
        .wstrb (creq.strobe),
        .wdata (creq.data),
        .ridx  (idx_s),
        .rdata (rdata_s)
    );

    // Read data is returned in the same cycle as ready; zero otherwise.
    always_comb begin
        cresp.ready = beat_go_s;
        cresp.last  = beat_go_s && (beat_r == len_r);
        if (beat_go_s && !is_write_r) begin
            cresp.data = rdata_s;
        end else begin
            cresp.data = 32'h0000_0000;
        end
    end

    assign busy = (state_r != CR_IDLE);

endmodule

// File: tb/tb_cbus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cbus_mem_responder
// Directed testbench for cbus_mem_responder (MEM_WORDS=4096, LATENCY=2).
// ---------------------------------------------------------------------------
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam int MW  = 4096;
    localparam int LAT = 2;

    logic       clk;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       busy;

    int tests;
    int fails;
    int first_gap;
    int ready_span;
    int beats_done;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    cbus_mem_responder #(
        .MEM_WORDS  (MW),
        .LATENCY    (LAT),
        .STALL_SEED (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One burst: accept, then sample at negedges; data for beat n+1 is driven
    // just after the edge that commits beat n. Stops early at abort_at beats.
    task automatic burst(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input msize_t size, input logic [3:0] strb, input int abort_at);
        int beat;
        int cyc;
        int first;
        int lastc;
        beat  = 0;
        cyc   = 0;
        first = -1;
        lastc = -1;
        @(negedge clk);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = addr;
        creq.len      = len;
        creq.size     = size;
        creq.strobe   = strb;
        creq.data     = wbuf[0];
        @(posedge clk);
        #1;
        while (beat <= int'(len) && beat < abort_at && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cresp.ready) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                rbuf[beat] = cresp.data;
                chk("last_flag", {63'd0, cresp.last}, {63'd0, (beat == int'(len))});
                beat++;
                @(posedge clk);
                #1;
                if (beat < 16) creq.data = wbuf[beat];
            end else begin
                chk("idle_zero", {31'd0, cresp.last, cresp.data}, 64'd0);
            end
        end
        creq.valid = 1'b0;
        beats_done = beat;
        chk("beat_count", 64'(beat), 64'((abort_at <= int'(len)) ? abort_at : int'(len) + 1));
        first_gap  = first - 1;
        ready_span = lastc - first + 1;
    endtask

    initial begin
        int seen;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        creq  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, cresp.ready}, 64'd0);
        chk("rst_last",  {63'd0, cresp.last},  64'd0);
        chk("rst_data",  {32'd0, cresp.data},  64'd0);
        chk("rst_busy",  {63'd0, busy},        64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Preload words 0x10..0x1F with their offset, then read them back.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
        burst(1'b1, 32'h0000_0040, MLEN16, MSIZE4, 4'b1111, 16);
        burst(1'b0, 32'h0000_0040, MLEN16, MSIZE4, 4'b1111, 16);
`ifndef CBUS_RESP_RANDOM_STALL_EN
        chk("first_gap", 64'(first_gap), 64'(LAT));
        chk("ready_span", 64'(ready_span), 64'd16);
`endif
        for (int i = 0; i < 16; i++) chk("rd_0x40", {32'd0, rbuf[i]}, 64'(i));
        @(negedge clk);
        chk("post_ready", {63'd0, cresp.ready}, 64'd0);
        chk("post_busy",  {63'd0, busy},        64'd0);

        // 16-beat write at 0x80 and readback.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hA0 + 32'(i);
        burst(1'b1, 32'h0000_0080, MLEN16, MSIZE4, 4'b1111, 16);
        burst(1'b0, 32'h0000_0080, MLEN16, MSIZE4, 4'b1111, 16);
        for (int i = 0; i < 16; i++) chk("rd_0x80", {32'd0, rbuf[i]}, 64'h0A0 + 64'(i));

        // Narrow byte write over a full word; a zero strobe writes nothing.
        wbuf[0] = 32'h1122_3344;
        burst(1'b1, 32'h0000_0104, MLEN1, MSIZE4, 4'b1111, 16);
        wbuf[0] = 32'h00CC_0000;
        burst(1'b1, 32'h0000_0104, MLEN1, MSIZE1, 4'b0100, 16);
        wbuf[0] = 32'hFFFF_FFFF;
        burst(1'b1, 32'h0000_0104, MLEN1, MSIZE4, 4'b0000, 16);
        burst(1'b0, 32'h0000_0104, MLEN1, MSIZE4, 4'b1111, 16);
        chk("narrow_wr", {32'd0, rbuf[0]}, 64'h11CC_3344);

        // Burst that wraps from the top of the array to word 0.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A0 + 32'(i);
        burst(1'b1, 32'(MW * 4 - 8), MLEN4, MSIZE4, 4'b1111, 16);
        burst(1'b0, 32'(MW * 4 - 8), MLEN4, MSIZE4, 4'b1111, 16);
        for (int i = 0; i < 4; i++) chk("wrap_rd", {32'd0, rbuf[i]}, 64'h5A0 + 64'(i));
        burst(1'b0, 32'h0000_0000, MLEN1, MSIZE4, 4'b1111, 16);
        chk("wrap_word0", {32'd0, rbuf[0]}, 64'h5A2);
        burst(1'b0, 32'(MW * 4 + 4), MLEN1, MSIZE4, 4'b1111, 16);
        chk("alias_word1", {32'd0, rbuf[0]}, 64'h5A3);

        // Valid dropped at beat 5 of a write: beats 5..15 keep the old zeros.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;
        burst(1'b1, 32'h0000_0200, MLEN16, MSIZE4, 4'b1111, 16);
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hB0 + 32'(i);
        burst(1'b1, 32'h0000_0200, MLEN16, MSIZE4, 4'b1111, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        burst(1'b0, 32'h0000_0200, MLEN16, MSIZE4, 4'b1111, 16);
        for (int i = 0; i < 16; i++)
            chk("abort_rd", {32'd0, rbuf[i]}, (i < 5) ? 64'h0B0 + 64'(i) : 64'd0);

        // Reset asserted mid-read for three cycles.
        @(negedge clk);
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.addr     = 32'h0000_0080;
        creq.len      = MLEN16;
        creq.size     = MSIZE4;
        seen = 0;
        for (int c = 0; c < 60 && seen < 3; c++) begin
            @(negedge clk);
            if (cresp.ready) seen++;
        end
        chk("rst_mid_beats", 64'(seen), 64'd3);
        reset = 1'b1;
        #1;
        chk("rstm_ready", {63'd0, cresp.ready}, 64'd0);
        chk("rstm_last",  {63'd0, cresp.last},  64'd0);
        chk("rstm_data",  {32'd0, cresp.data},  64'd0);
        chk("rstm_busy",  {63'd0, busy},        64'd0);
        creq.valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        burst(1'b0, 32'h0000_0080, MLEN16, MSIZE4, 4'b1111, 16);
        for (int i = 0; i < 16; i++) chk("post_rst_rd", {32'd0, rbuf[i]}, 64'h0A0 + 64'(i));
        burst(1'b0, 32'h0000_0104, MLEN1, MSIZE4, 4'b1111, 16);
        chk("post_rst_word", {32'd0, rbuf[0]}, 64'h11CC_3344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
